// File: rtl/uart_pkg.sv
// Shared definitions for the button-driven UART message sender: timing constants,
// message FSM state encoding and the fixed message ROM.
package uart_pkg;

  localparam int unsigned CLK_HZ   = 48000000;
  localparam int unsigned BAUD_DIV = 5000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_FINISH    = 3'd5
  } msg_state_e;

  // "Hello!\r\n"; entries past the message length read as zero.
  function automatic logic [7:0] msg_rom(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h48;
      4'd1:    b = 8'h65;
      4'd2:    b = 8'h6C;
      4'd3:    b = 8'h6C;
      4'd4:    b = 8'h6F;
      4'd5:    b = 8'h21;
      4'd6:    b = 8'h0D;
      4'd7:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, saturating-free debounce counter
// and a one-cycle press strobe on the 0->1 edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/button_msg_sender.sv
// Sends the ROM message byte-by-byte to the UART transmitter on each debounced
// button press, using the data/flag_start/flag_busy handshake.
module button_msg_sender #(
  parameter int unsigned CLK_HZ          = 48000000,
  parameter int unsigned DEBOUNCE_CYCLES = 480000,
  parameter int unsigned MSG_LEN         = 8,
  parameter int unsigned ACK_TIMEOUT     = 16383
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       flag_busy,
  output logic [7:0] data,
  output logic       flag_start,
  output logic       sending,
  output logic       msg_done,
  output logic       err_timeout
);

  import uart_pkg::*;

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic btn_level, btn_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .level(btn_level),
    .press(btn_press)
  );

  msg_state_e    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      start_q <= start_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_press && btn_level) begin
          idx_d   = '0;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!flag_busy) begin
          data_d  = msg_rom(idx_q);
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = ST_REQ;
        end
      end
      // flag_start stays high for exactly ACK_TIMEOUT cycles if busy never answers.
      ST_REQ: begin
        if (flag_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          start_d = 1'b1;
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!flag_busy) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == 4'(MSG_LEN - 1)) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign data        = data_q;
  assign flag_start  = start_q;
  assign err_timeout = err_q;
  assign sending     = (state_q != ST_IDLE);
  assign msg_done    = (state_q == ST_FINISH);

endmodule
